// File: rtl/ex_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the EX-stage hazard controller.
// The datapath (master) drives register ids and resolution flags; the controller (slave) returns selects and enables.
interface ex_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs_ID;
    logic [4:0]       rt_ID;
    logic [4:0]       rs_EX;
    logic [4:0]       rt_EX;
    logic             MemRead_EX;
    logic [4:0]       rtd_EX;
    logic             RegWrite_MEM;
    logic             RegWrite_WB;
    logic [4:0]       rtd_MEM;
    logic [4:0]       rtd_WB;
    logic             Branch_MEM;
    logic             Zero_MEM;
    logic             jump_MEM;
    logic             halt_req;
    logic [1:0]       ForwardA;
    logic [1:0]       ForwardB;
    logic             pc_en;
    logic [1:0]       pc_src;
    logic             if_id_en;
    logic             id_ex_bubble;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             flush_ex_mem;
    logic             halt_ack;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output rs_ID, rt_ID, rs_EX, rt_EX, MemRead_EX, rtd_EX,
               RegWrite_MEM, RegWrite_WB, rtd_MEM, rtd_WB,
               Branch_MEM, Zero_MEM, jump_MEM, halt_req,
        input  ForwardA, ForwardB, pc_en, pc_src, if_id_en, id_ex_bubble,
               flush_if_id, flush_id_ex, flush_ex_mem, halt_ack, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs_ID, rt_ID, rs_EX, rt_EX, MemRead_EX, rtd_EX,
               RegWrite_MEM, RegWrite_WB, rtd_MEM, rtd_WB,
               Branch_MEM, Zero_MEM, jump_MEM, halt_req,
        output ForwardA, ForwardB, pc_en, pc_src, if_id_en, id_ex_bubble,
               flush_if_id, flush_id_ex, flush_ex_mem, halt_ack, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: operand forwarding, load-use stall, MEM-resolved redirect/flush,
// halt/drain handshake for debug stepping, and saturating stall/flush event counters.
module ex_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    ex_hazard_ctrl_if.slave hz
);
    localparam int DC_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DC_W-1:0] DRAIN_LOAD = DC_W'(DRAIN_CYCLES);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t           state;
    logic [DC_W-1:0]  drain_cnt;
    logic             halt_ack_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic             taken;
    logic             lu;
    logic             stall_run;
    logic             pc_en_c;
    logic             if_id_en_c;
    logic             bubble_c;
    logic [1:0]       pc_src_c;

    // MEM result is the younger producer, so its match is checked first.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic mem_wr, input logic [4:0] mem_rd,
                                           input logic wb_wr,  input logic [4:0] wb_rd);
        if (mem_wr && mem_rd != 5'd0 && mem_rd == src)
            return 2'd2;
        else if (wb_wr && wb_rd != 5'd0 && wb_rd == src)
            return 2'd1;
        else
            return 2'd0;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign taken     = hz.jump_MEM | (hz.Branch_MEM & hz.Zero_MEM);
    assign lu        = hz.MemRead_EX && hz.rtd_EX != 5'd0 &&
                       (hz.rtd_EX == hz.rs_ID || hz.rtd_EX == hz.rt_ID);
    assign stall_run = (state == RUN) && lu && !taken;

    always_comb begin
        pc_src_c   = hz.jump_MEM ? 2'd2 : (taken ? 2'd1 : 2'd0);
        pc_en_c    = taken;
        if_id_en_c = 1'b0;
        bubble_c   = 1'b1;
        if (state == RUN) begin
            pc_en_c    = !stall_run;
            if_id_en_c = !stall_run;
            bubble_c   = stall_run;
        end
    end

    assign hz.ForwardA     = fwd_sel(hz.rs_EX, hz.RegWrite_MEM, hz.rtd_MEM, hz.RegWrite_WB, hz.rtd_WB);
    assign hz.ForwardB     = fwd_sel(hz.rt_EX, hz.RegWrite_MEM, hz.rtd_MEM, hz.RegWrite_WB, hz.rtd_WB);
    assign hz.pc_en        = pc_en_c;
    assign hz.pc_src       = pc_src_c;
    assign hz.if_id_en     = if_id_en_c;
    assign hz.id_ex_bubble = bubble_c;
    assign hz.flush_if_id  = taken;
    assign hz.flush_id_ex  = taken;
    assign hz.flush_ex_mem = taken;
    assign hz.halt_ack     = halt_ack_q;
    assign hz.stall_cnt    = stall_cnt_q;
    assign hz.flush_cnt    = flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            drain_cnt   <= '0;
            halt_ack_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_run)
                stall_cnt_q <= sat_inc(stall_cnt_q);
            if (taken)
                flush_cnt_q <= sat_inc(flush_cnt_q);

            case (state)
                RUN: begin
                    if (hz.halt_req) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    // Drain always completes so halt_ack is seen even if halt_req already dropped.
                    drain_cnt <= drain_cnt - 1'b1;
                    if (drain_cnt <= DC_W'(1)) begin
                        state      <= HALTED;
                        halt_ack_q <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!hz.halt_req) begin
                        state      <= RUN;
                        halt_ack_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= RUN;
                    halt_ack_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Randomized and directed bench for ex_hazard_ctrl against a cycle-indexed behavioural model.
module tb_ex_hazard_ctrl;
    localparam int DRAIN_CYCLES = 3;
    localparam int CNT_W        = 16;
    localparam int MAXC         = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;

    ex_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    ex_hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: halting is tracked by absolute cycle index, not a state machine.
    int m_stall;
    int m_flush;
    bit m_halting;
    int m_halted_from;
    int cyc;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int m_mode();
        if (!m_halting) return 0;
        if (cyc < m_halted_from) return 1;
        return 2;
    endfunction

    function automatic int fwd_exp(input logic [4:0] src);
        if (hz.RegWrite_MEM && hz.rtd_MEM != 0 && hz.rtd_MEM == src) return 2;
        if (hz.RegWrite_WB && hz.rtd_WB != 0 && hz.rtd_WB == src) return 1;
        return 0;
    endfunction

    function automatic bit taken_exp();
        return hz.jump_MEM || (hz.Branch_MEM && hz.Zero_MEM);
    endfunction

    function automatic bit lu_exp();
        return hz.MemRead_EX && hz.rtd_EX != 0 &&
               (hz.rtd_EX == hz.rs_ID || hz.rtd_EX == hz.rt_ID);
    endfunction

    task automatic model_reset();
        m_stall   = 0;
        m_flush   = 0;
        m_halting = 0;
        m_halted_from = 0;
        cyc       = 0;
    endtask

    task automatic check_outputs();
        bit t, stall;
        int mode;
        t     = taken_exp();
        mode  = m_mode();
        stall = (mode == 0) && lu_exp() && !t;
        chk_val("ForwardA", hz.ForwardA, fwd_exp(hz.rs_EX));
        chk_val("ForwardB", hz.ForwardB, fwd_exp(hz.rt_EX));
        chk_val("pc_src", hz.pc_src, hz.jump_MEM ? 2 : (t ? 1 : 0));
        chk_val("pc_en", hz.pc_en, (mode == 0) ? !stall : t);
        chk_val("if_id_en", hz.if_id_en, (mode == 0) && !stall);
        chk_val("id_ex_bubble", hz.id_ex_bubble, (mode != 0) || stall);
        chk_val("flush_if_id", hz.flush_if_id, t);
        chk_val("flush_id_ex", hz.flush_id_ex, t);
        chk_val("flush_ex_mem", hz.flush_ex_mem, t);
        chk_val("halt_ack", hz.halt_ack, mode == 2);
        chk_val("stall_cnt", hz.stall_cnt, m_stall);
        chk_val("flush_cnt", hz.flush_cnt, m_flush);
    endtask

    task automatic model_edge();
        int mode;
        mode = m_mode();
        if (mode == 0 && lu_exp() && !taken_exp() && m_stall < MAXC) m_stall++;
        if (taken_exp() && m_flush < MAXC) m_flush++;
        if (mode == 0 && hz.halt_req) begin
            m_halting     = 1;
            m_halted_from = cyc + 1 + DRAIN_CYCLES;
        end else if (mode == 2 && !hz.halt_req) begin
            m_halting = 0;
        end
        cyc++;
    endtask

    task automatic step(input bit do_chk);
        #1;
        if (do_chk) check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        hz.rs_ID = 0; hz.rt_ID = 0; hz.rs_EX = 0; hz.rt_EX = 0;
        hz.MemRead_EX = 0; hz.rtd_EX = 0;
        hz.RegWrite_MEM = 0; hz.RegWrite_WB = 0; hz.rtd_MEM = 0; hz.rtd_WB = 0;
        hz.Branch_MEM = 0; hz.Zero_MEM = 0; hz.jump_MEM = 0; hz.halt_req = 0;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clr_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Reset decoding with all inputs low.
        check_outputs();
        rst_n = 1'b1;

        // Forwarding priority.
        hz.rs_EX = 5; hz.rt_EX = 5; hz.RegWrite_MEM = 1; hz.rtd_MEM = 5; hz.RegWrite_WB = 1; hz.rtd_WB = 5;
        #1; chk_val("fwdA_mem", hz.ForwardA, 2); chk_val("fwdB_mem", hz.ForwardB, 2);
        step(1);
        hz.rtd_MEM = 0;
        #1; chk_val("fwdA_wb", hz.ForwardA, 1); chk_val("fwdB_wb", hz.ForwardB, 1);
        step(1);
        hz.rtd_WB = 0;
        #1; chk_val("fwdA_rf", hz.ForwardA, 0); chk_val("fwdB_rf", hz.ForwardB, 0);
        step(1);
        clr_inputs();

        // Load-use stall for one cycle.
        hz.MemRead_EX = 1; hz.rtd_EX = 8; hz.rt_ID = 8;
        #1;
        chk_val("lu_pc_en", hz.pc_en, 0);
        chk_val("lu_if_id_en", hz.if_id_en, 0);
        chk_val("lu_bubble", hz.id_ex_bubble, 1);
        step(1);
        hz.rtd_EX = 0; hz.rt_ID = 0;
        #1;
        chk_val("lu_stall_cnt", hz.stall_cnt, 1);
        chk_val("lu_r0_pc_en", hz.pc_en, 1);
        step(1);

        // Redirect overrides a load-use stall.
        hz.rtd_EX = 8; hz.rt_ID = 8; hz.Branch_MEM = 1; hz.Zero_MEM = 1;
        #1;
        chk_val("redir_pc_src", hz.pc_src, 1);
        chk_val("redir_pc_en", hz.pc_en, 1);
        chk_val("redir_flush_ex_mem", hz.flush_ex_mem, 1);
        step(1);
        hz.jump_MEM = 1;
        #1;
        chk_val("redir_stall_hold", hz.stall_cnt, 1);
        chk_val("redir_flush_cnt", hz.flush_cnt, 1);
        chk_val("jump_pc_src", hz.pc_src, 2);
        step(1);
        clr_inputs();

        // Halt handshake with a taken branch in the second drain cycle.
        hz.halt_req = 1;
        step(1);
        for (int k = 1; k <= DRAIN_CYCLES; k++) begin
            hz.Branch_MEM = (k == 2); hz.Zero_MEM = (k == 2);
            #1;
            chk_val("drain_bubble", hz.id_ex_bubble, 1);
            chk_val("drain_halt_ack", hz.halt_ack, 0);
            if (k == 2) begin
                chk_val("drain_redir_pc_en", hz.pc_en, 1);
                chk_val("drain_redir_flush", hz.flush_if_id, 1);
            end
            step(1);
        end
        hz.Branch_MEM = 0; hz.Zero_MEM = 0;
        #1; chk_val("halt_ack_on_time", hz.halt_ack, 1);
        step(1);
        hz.halt_req = 0;
        step(1);
        #1;
        chk_val("resume_halt_ack", hz.halt_ack, 0);
        chk_val("resume_pc_en", hz.pc_en, 1);
        step(1);

        // Asynchronous reset while HALTED.
        hz.halt_req = 1;
        repeat (DRAIN_CYCLES + 3) step(1);
        rst_n = 1'b0;
        #1;
        chk_val("arst_halt_ack", hz.halt_ack, 0);
        chk_val("arst_pc_en", hz.pc_en, 1);
        chk_val("arst_bubble", hz.id_ex_bubble, 0);
        chk_val("arst_stall_cnt", hz.stall_cnt, 0);
        chk_val("arst_flush_cnt", hz.flush_cnt, 0);
        rst_n = 1'b1;
        model_reset();
        clr_inputs();
        step(1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            hz.rs_ID = 5'($urandom_range(0, 3)); hz.rt_ID = 5'($urandom_range(0, 3));
            hz.rs_EX = 5'($urandom_range(0, 3)); hz.rt_EX = 5'($urandom_range(0, 3));
            hz.MemRead_EX = 1'($urandom_range(0, 1)); hz.rtd_EX = 5'($urandom_range(0, 3));
            hz.RegWrite_MEM = 1'($urandom_range(0, 1)); hz.rtd_MEM = 5'($urandom_range(0, 3));
            hz.RegWrite_WB = 1'($urandom_range(0, 1)); hz.rtd_WB = 5'($urandom_range(0, 3));
            hz.Branch_MEM = 1'($urandom_range(0, 1)); hz.Zero_MEM = 1'($urandom_range(0, 2) == 0);
            hz.jump_MEM = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) hz.halt_req = ~hz.halt_req;
            if (i % 997 == 500) reset_pulse();
            step(1);
        end
        clr_inputs();

        // Stall counter saturation.
        reset_pulse();
        hz.MemRead_EX = 1; hz.rtd_EX = 8; hz.rt_ID = 8;
        for (int i = 0; i < MAXC + 5; i++) step(0);
        step(1);
        #1; chk_val("stall_cnt_sat", hz.stall_cnt, MAXC);
        clr_inputs();
        step(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ex_hazard_ctrl.md
# ex_hazard_ctrl

Pipeline controller that sequences the EX-stage datapath and the stage registers around it. It generates the ForwardA/ForwardB operand selects consumed by the EX stage. It detects load-use hazards and stalls IF/ID while bubbling ID/EX. It redirects and flushes on branches and jumps resolved in MEM, and runs a halt/drain handshake for debug single-stepping. Saturating stall and flush counters support performance measurement.

## Interface
- DRAIN_CYCLES, 3: bubble cycles needed to empty EX, MEM and WB before halt is acknowledged (≥1).
- CNT_W, 16: width of the performance counters.

- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rs_ID, rt_ID  in  5  source registers of the instruction in ID.
- rs_EX, rt_EX  in  5  source registers of the instruction in EX.
- MemRead_EX  in  1  instruction in EX is a load.
- rtd_EX  in  5  destination of the instruction in EX.
- RegWrite_MEM, RegWrite_WB  in  1  the MEM / WB instruction writes a register.
- rtd_MEM, rtd_WB  in  5  destination registers in MEM / WB.
- Branch_MEM, Zero_MEM, jump_MEM  in  1  control-transfer resolution in MEM.
- halt_req  in  1  level request to halt the pipeline.
- ForwardA, ForwardB  out  2  0 = register file, 1 = WB result, 2 = MEM result.
- pc_en  out  1  PC register write enable.
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target.
- if_id_en  out  1  IF/ID write enable.
- id_ex_bubble  out  1  load a NOP (all controls 0) into ID/EX.
- flush_if_id, flush_id_ex, flush_ex_mem  out  1  clear the corresponding stage register.
- halt_ack  out  1  pipeline is empty and halted.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

## Operation
- Forwarding is combinational and applies in every state.
  - ForwardA = 2 if RegWrite_MEM && rtd_MEM≠0 && rtd_MEM==rs_EX.
  - Otherwise ForwardA = 1 if RegWrite_WB && rtd_WB≠0 && rtd_WB==rs_EX.
  - Otherwise ForwardA = 0.
  - ForwardB is identical, using rt_EX. The MEM match always wins over the WB match.
- Redirect: taken = jump_MEM | (Branch_MEM & Zero_MEM). Jump has priority, so pc_src = 2 if jump_MEM, else 1 if taken, else 0.
  - On taken, in any state: pc_en=1 and flush_if_id = flush_id_ex = flush_ex_mem = 1.
- Load-use: lu = MemRead_EX && rtd_EX≠0 && (rtd_EX==rs_ID || rtd_EX==rt_ID).
- FSM states are RUN, DRAIN and HALTED.
- RUN:
  - Taken overrides lu; the stall is suppressed.
  - On lu without taken: pc_en=0, if_id_en=0, id_ex_bubble=1.
  - Otherwise: pc_en=1, if_id_en=1, id_ex_bubble=0.
  - If halt_req=1, go to DRAIN and load drain_cnt=DRAIN_CYCLES.
- DRAIN:
  - Outputs: pc_en = taken, if_id_en=0, id_ex_bubble=1, no lu stall counted.
  - drain_cnt decrements each cycle. Go to HALTED in the cycle after drain_cnt==1.
  - A taken redirect inside DRAIN flushes the held IF/ID instruction and updates the PC. Draining continues.
- HALTED:
  - Outputs: halt_ack=1, pc_en=0, if_id_en=0, id_ex_bubble=1.
  - When halt_req=0, return to RUN.
  - halt_ack is high for at least one cycle, even if halt_req fell during DRAIN.
- stall_cnt increments on every RUN cycle with lu && !taken. flush_cnt increments on every taken cycle in any state.
  - Both counters hold at 2^CNT_W−1 and never wrap.

## Timing
- Forward, stall, flush, pc_src and pc_en outputs are combinational from the inputs and the current state. They take effect at the next edge.
- A load-use stall lasts exactly 1 cycle: after the edge, the load is in MEM and lu deasserts.
- Halt latency: halt_req seen at edge N → DRAIN for cycles N+1 … N+DRAIN_CYCLES → halt_ack high from cycle N+DRAIN_CYCLES+1.
- Resume: halt_req low in HALTED → RUN at the next edge, and fetch resumes from the held PC.
- Reset (rst_n=0, asynchronous):
  - state=RUN, drain_cnt=0, halt_ack=0, stall_cnt=0, flush_cnt=0.
  - Combinational outputs follow RUN decoding. With all inputs 0: ForwardA/B=0, pc_en=1, if_id_en=1, pc_src=0, all flushes and the bubble = 0.
- Reset mid-DRAIN or mid-HALTED returns immediately to RUN with halt_ack=0.

## Test plan
- Forwarding priority: rs_EX=rt_EX=5, RegWrite_MEM=1, rtd_MEM=5, RegWrite_WB=1, rtd_WB=5 → ForwardA=ForwardB=2. Then rtd_MEM=0 → both =1. Then rtd_WB=0 → both =0.
- Load-use: MemRead_EX=1, rtd_EX=8, rt_ID=8 for one cycle → pc_en=0, if_id_en=0, id_ex_bubble=1, stall_cnt 0→1. With rtd_EX=0 → no stall.
- Redirect over stall: lu true together with Branch_MEM=Zero_MEM=1 → pc_src=1, pc_en=1, all three flushes =1, stall_cnt unchanged, flush_cnt +1. jump_MEM=1 plus a taken branch → pc_src=2.
- Halt handshake, DRAIN_CYCLES=3: halt_req high at edge 0 → bubbles in cycles 1–3, halt_ack=1 from cycle 4 → drop halt_req → RUN at the next edge, halt_ack=0.
- Redirect during DRAIN: taken in the second drain cycle → pc_en=1, flush_if_id=1. halt_ack still rises on schedule.
- Saturation and async reset: drive lu continuously for more than 65535 cycles → stall_cnt holds at 0xFFFF. Pulse rst_n low between clock edges → counters 0 and state RUN immediately.
